// File: rtl/obstacle_scheduler_if.sv
// Row handshake between the obstacle scheduler and the scroller/renderer.
// The master (scheduler) presents the FIFO head row with row_valid. The slave
// accepts that row by asserting row_ready.
//   row_valid : head entry present
//   row_ready : consumer takes the head entry on this edge
//   row_top/row_mid/row_bot : lane shapes of the head entry (00 = clear)
interface obstacle_scheduler_if;
  logic       row_valid;
  logic       row_ready;
  logic [1:0] row_top;
  logic [1:0] row_mid;
  logic [1:0] row_bot;

  modport master (
    output row_valid, row_top, row_mid, row_bot,
    input  row_ready
  );

  modport slave (
    input  row_valid, row_top, row_mid, row_bot,
    output row_ready
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler for the running-man game.
// It counts video frames and fires the shape generator's update strobe at an
// interval set by the difficulty level. It samples the three lane shapes that
// come back and re-rolls any row that blocks every lane. Accepted rows are
// queued in a 4-deep first-word-fall-through FIFO for the renderer.
//   clk, reset_n      : clock, asynchronous active-low reset
//   frame_tick_i      : one-cycle pulse per video frame
//   run_i             : 1 = running, 0 = paused
//   game_over_i       : collision flag; enters sticky HALT
//   rand_val_i        : LFSR state; bits [1:0] jitter the spawn period
//   shape_update_o    : one-cycle strobe to the shape generator
//   top/mid/bot_in_i  : shape generator lane outputs
//   row_if            : FIFO head handshake (master side)
//   level_o           : difficulty level, saturating at 15
//   spawn_count_o     : accepted rows, wrapping at 255
module obstacle_scheduler #(
  parameter int unsigned INIT_PERIOD      = 60,
  parameter int unsigned MIN_PERIOD       = 20,
  parameter int unsigned STEP             = 4,
  parameter int unsigned SPAWNS_PER_LEVEL = 8,
  parameter int unsigned MAX_REROLL       = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        frame_tick_i,
  input  logic                        run_i,
  input  logic                        game_over_i,
  input  logic [11:0]                 rand_val_i,
  output logic                        shape_update_o,
  input  logic [1:0]                  top_in_i,
  input  logic [1:0]                  mid_in_i,
  input  logic [1:0]                  bot_in_i,
  obstacle_scheduler_if.master        row_if,
  output logic [3:0]                  level_o,
  output logic [7:0]                  spawn_count_o
);

  localparam int unsigned RW = (MAX_REROLL > 0) ? $clog2(MAX_REROLL + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_UPDATE, S_SAMPLE, S_CHECK, S_PUSH, S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [RW-1:0]   reroll_q, reroll_d;
  logic [5:0]      hold_q, hold_d;      // {top, mid, bot}
  logic [3:0]      level_q, level_d;
  logic [7:0]      spawn_q, spawn_d;

  logic [5:0]      mem_q [4];
  logic [1:0]      wr_q, rd_q;
  logic [2:0]      occ_q;
  logic            fifo_empty, fifo_full, push, pop;

  logic [7:0]      spawn_inc;
  logic [3:0]      level_push, period_lvl;
  logic signed [8:0] period_s;
  logic [7:0]      period, reload;
  logic            unused_rand;

  always_comb unused_rand = ^rand_val_i[11:2];

  // Level bump is resolved before the reload so the new period applies to the
  // reload made by the same write.
  always_comb begin
    spawn_inc  = spawn_q + 8'd1;
    level_push = level_q;
    if (spawn_inc != '0 && (spawn_inc % 8'(SPAWNS_PER_LEVEL)) == '0 && level_q != 4'hF)
      level_push = level_q + 4'd1;
    period_lvl = (state_q == S_PUSH) ? level_push : level_q;
  end

  // Signed 9-bit difference so a high level cannot wrap below the floor.
  always_comb begin
    period_s = $signed(9'(INIT_PERIOD)) - $signed(9'(period_lvl) * 9'(STEP));
    if (period_s < $signed(9'(MIN_PERIOD)))
      period = 8'(MIN_PERIOD);
    else
      period = period_s[7:0];
    reload = period + {6'd0, rand_val_i[1:0]};
  end

  always_comb begin
    fifo_empty       = (occ_q == 3'd0);
    fifo_full        = (occ_q == 3'd4);
    row_if.row_valid = !fifo_empty && (state_q != S_HALT);
    pop              = row_if.row_valid && row_if.row_ready;
    row_if.row_top   = fifo_empty ? 2'b00 : mem_q[rd_q][5:4];
    row_if.row_mid   = fifo_empty ? 2'b00 : mem_q[rd_q][3:2];
    row_if.row_bot   = fifo_empty ? 2'b00 : mem_q[rd_q][1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reroll_d = reroll_q;
    hold_d   = hold_q;
    level_d  = level_q;
    spawn_d  = spawn_q;
    push     = 1'b0;
    if (game_over_i) begin
      state_d = S_HALT;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (run_i) begin
            cnt_d   = reload;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (run_i && frame_tick_i) begin
            if (cnt_q == 8'd1) state_d = S_UPDATE;
            else               cnt_d   = cnt_q - 8'd1;
          end
        end
        S_UPDATE: state_d = S_SAMPLE;
        S_SAMPLE: begin
          hold_d  = {top_in_i, mid_in_i, bot_in_i};
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (hold_q[5:4] != '0 && hold_q[3:2] != '0 && hold_q[1:0] != '0) begin
            if (reroll_q < RW'(MAX_REROLL)) begin
              reroll_d = reroll_q + RW'(1);
              state_d  = S_UPDATE;
            end else begin
              hold_d[3:2] = 2'b00;       // open a gap in the middle lane
              state_d     = S_PUSH;
            end
          end else begin
            state_d = S_PUSH;
          end
        end
        S_PUSH: begin
          if (!fifo_full || pop) begin
            push     = 1'b1;
            spawn_d  = spawn_inc;
            level_d  = level_push;
            reroll_d = '0;
            cnt_d    = reload;
            state_d  = S_WAIT;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    shape_update_o = (state_q == S_UPDATE);
    level_o        = level_q;
    spawn_count_o  = spawn_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      reroll_q <= '0;
      hold_q   <= '0;
      level_q  <= '0;
      spawn_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reroll_q <= reroll_d;
      hold_q   <= hold_d;
      level_q  <= level_d;
      spawn_q  <= spawn_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= hold_q;
        wr_q        <= wr_q + 2'd1;
      end
      if (pop) rd_q <= rd_q + 2'd1;
      if (push && !pop)      occ_q <= occ_q + 3'd1;
      else if (pop && !push) occ_q <= occ_q - 3'd1;
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
module tb_obstacle_scheduler;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        frame_tick = 1'b0, run = 1'b0, game_over = 1'b0;
  logic [11:0] rand_val = '0;
  logic [1:0]  top_in = '0, mid_in = '0, bot_in = '0;
  logic        shape_update;
  logic [3:0]  level;
  logic [7:0]  spawn_count;

  obstacle_scheduler_if row_if ();

  always #5 clk = ~clk;

  obstacle_scheduler #(
    .INIT_PERIOD(60), .MIN_PERIOD(20), .STEP(4),
    .SPAWNS_PER_LEVEL(8), .MAX_REROLL(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick_i(frame_tick), .run_i(run),
    .game_over_i(game_over), .rand_val_i(rand_val), .shape_update_o(shape_update),
    .top_in_i(top_in), .mid_in_i(mid_in), .bot_in_i(bot_in), .row_if(row_if),
    .level_o(level), .spawn_count_o(spawn_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames are counted down in plain integers, and the
  // strobe/settle/decide steps are tracked as "cycles since strobe". The
  // FIFO is a queue.
  bit         m_started, m_halted, m_storing;
  int         m_left, m_since, m_tries, m_spawns, m_lvl;
  logic [5:0] m_held;
  logic [5:0] m_q[$];

  function automatic int period_of(input int lv);
    int p;
    p = 60 - 4 * lv;
    return (p < 20) ? 20 : p;
  endfunction

  task automatic model_reset();
    m_started = 0; m_halted = 0; m_storing = 0;
    m_left = 0; m_since = -1; m_tries = 0; m_spawns = 0; m_lvl = 0;
    m_held = '0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit pop, push;
    pop  = !m_halted && (m_q.size() > 0) && (row_if.row_ready == 1'b1);
    push = 0;
    if (m_halted) return;
    if (game_over) begin
      if (pop) void'(m_q.pop_front());
      m_halted = 1;
      return;
    end
    if (!m_started) begin
      if (run) begin
        m_started = 1;
        m_left = period_of(m_lvl) + int'(rand_val[1:0]);
      end
    end else if (m_storing) begin
      if (m_q.size() < 4 || pop) begin
        push = 1;
        m_spawns = (m_spawns + 1) % 256;
        if (m_spawns != 0 && m_spawns % 8 == 0 && m_lvl < 15) m_lvl++;
        m_tries = 0;
        m_left = period_of(m_lvl) + int'(rand_val[1:0]);
        m_storing = 0;
      end
    end else if (m_since == 0) begin
      m_since = 1;
    end else if (m_since == 1) begin
      m_held = {top_in, mid_in, bot_in};
      m_since = 2;
    end else if (m_since == 2) begin
      m_since = -1;
      if (m_held[5:4] != 0 && m_held[3:2] != 0 && m_held[1:0] != 0) begin
        if (m_tries < 3) begin
          m_tries++;
          m_since = 0;
        end else begin
          m_held[3:2] = 2'b00;
          m_storing = 1;
        end
      end else begin
        m_storing = 1;
      end
    end else if (run && frame_tick) begin
      if (m_left == 1) m_since = 0;
      else m_left--;
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(m_held);
  endtask

  initial model_reset();

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (reset_n) begin
      logic [5:0] head;
      head = (m_q.size() > 0) ? m_q[0] : 6'd0;
      chk("shape_update", int'(shape_update), int'(m_since == 0 && !m_halted));
      chk("row_valid", int'(row_if.row_valid), int'(m_q.size() > 0 && !m_halted));
      chk("row_top", int'(row_if.row_top), int'(head[5:4]));
      chk("row_mid", int'(row_if.row_mid), int'(head[3:2]));
      chk("row_bot", int'(row_if.row_bot), int'(head[1:0]));
      chk("level", int'(level), m_lvl);
      chk("spawn_count", int'(spawn_count), m_spawns);
    end
  end

  int cyc, ntick, last_tick, nstrobe, prev, nvalid, base;
  bit got, done, s80, s88;

  initial begin
    row_if.row_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_shape_update", int'(shape_update), 0);
    chk("reset_row_valid", int'(row_if.row_valid), 0);
    chk("reset_level", int'(level), 0);
    chk("reset_spawn", int'(spawn_count), 0);

    // First spawn: 60 ticks spaced 10 cycles apart, no jitter.
    @(negedge clk);
    reset_n = 1'b1; run = 1'b1;
    top_in = 2'b01; mid_in = 2'b10; bot_in = 2'b00;
    row_if.row_ready = 1'b1;
    cyc = 0; ntick = 0; last_tick = -100; got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk); cyc++;
      frame_tick = 1'b0;
      if (shape_update) begin
        got = 1;
        chk("first_strobe_ticks", ntick, 60);
        chk("strobe_after_tick", cyc - last_tick, 1);
      end else if (cyc % 10 == 0) begin
        frame_tick = 1'b1; ntick++; last_tick = cyc;
      end
    end
    chk("first_strobe_seen", int'(got), 1);
    @(negedge clk); cyc++;
    chk("strobe_single_cycle", int'(shape_update), 0);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (row_if.row_valid) done = 1;
      else begin @(negedge clk); cyc++; end
    end
    chk("row1_valid", int'(row_if.row_valid), 1);
    chk("row1_top", int'(row_if.row_top), 1);
    chk("row1_mid", int'(row_if.row_mid), 2);
    chk("row1_bot", int'(row_if.row_bot), 0);
    chk("row1_spawn", int'(spawn_count), 1);
    @(negedge clk); cyc++;
    chk("row1_popped", int'(row_if.row_valid), 0);

    // Fully blocked row: three re-rolls, then the middle lane is opened.
    top_in = 2'b11; mid_in = 2'b11; bot_in = 2'b01;
    nstrobe = 0; prev = 0; done = 0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk); cyc++;
      frame_tick = (cyc % 2 == 0);
      if (shape_update) begin
        if (nstrobe > 0) chk("reroll_spacing", cyc - prev, 3);
        prev = cyc; nstrobe++;
      end
      if (row_if.row_valid) done = 1;
    end
    chk("reroll_strobes", nstrobe, 4);
    chk("forced_top", int'(row_if.row_top), 3);
    chk("forced_mid", int'(row_if.row_mid), 0);
    chk("forced_bot", int'(row_if.row_bot), 1);
    @(negedge clk); cyc++;
    frame_tick = 1'b0;

    // Back-pressure: fill the FIFO, stall in the write step, then release.
    row_if.row_ready = 1'b0;
    top_in = 2'b01; mid_in = 2'b00; bot_in = 2'b00;
    base = int'(spawn_count);
    for (int i = 0; i < 20000 && int'(spawn_count) != base + 4; i++) begin
      @(negedge clk); cyc++;
      frame_tick = (cyc % 2 == 0);
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); cyc++;
      frame_tick = (cyc % 2 == 0);
    end
    frame_tick = 1'b0;
    chk("stall_spawn", int'(spawn_count), base + 4);
    chk("stall_valid", int'(row_if.row_valid), 1);
    row_if.row_ready = 1'b1;
    @(negedge clk); cyc++;
    chk("push_with_pop", int'(spawn_count), base + 5);

    // Randomised run up to 120 accepted rows.
    s80 = 0; s88 = 0;
    for (int i = 0; i < 70000 && spawn_count != 8'd120; i++) begin
      @(negedge clk);
      if (spawn_count == 8'd80 && !s80) begin s80 = 1; chk("level_at_80", int'(level), 10); end
      if (spawn_count == 8'd88 && !s88) begin s88 = 1; chk("level_at_88", int'(level), 11); end
      frame_tick = 1'($urandom_range(1, 0));
      run = ($urandom_range(9, 0) != 0);
      row_if.row_ready = 1'($urandom_range(1, 0));
      rand_val = 12'($urandom);
      top_in = 2'($urandom_range(3, 0));
      mid_in = 2'($urandom_range(3, 0));
      bot_in = 2'($urandom_range(3, 0));
    end
    chk("spawn_reached_120", int'(spawn_count), 120);
    chk("level_at_120", int'(level), 15);

    // Halt, then asynchronous reset between edges.
    run = 1'b1;
    for (int i = 0; i < int'($urandom_range(40, 0)); i++) begin
      @(negedge clk);
      frame_tick = 1'($urandom_range(1, 0));
    end
    @(negedge clk);
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    nstrobe = 0; nvalid = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (shape_update) nstrobe++;
      if (row_if.row_valid) nvalid++;
      frame_tick = (i % 2 == 0);
      row_if.row_ready = 1'($urandom_range(1, 0));
    end
    chk("halt_strobes", nstrobe, 0);
    chk("halt_valid", nvalid, 0);
    chk("halt_level_kept", int'(level), 15);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_shape_update", int'(shape_update), 0);
    chk("async_row_valid", int'(row_if.row_valid), 0);
    chk("async_row", int'({row_if.row_top, row_if.row_mid, row_if.row_bot}), 0);
    chk("async_level", int'(level), 0);
    chk("async_spawn", int'(spawn_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
Sequences the LFSR-driven shape generator for the running-man game. It counts video frames, fires the shape generator's update strobe at a difficulty-dependent interval, and samples the three lane shapes it returns. It re-rolls any row that blocks every lane, then queues accepted rows in a small FIFO for the scroller/renderer through a valid/ready handshake.

Parameters:
INIT_PERIOD, 60, frames between spawns at level 0 (8-bit)
MIN_PERIOD, 20, floor on spawn period
STEP, 4, period decrease per level
SPAWNS_PER_LEVEL, 8, accepted rows per level increment
MAX_REROLL, 3, re-rolls allowed before forcing a gap

Ports:
clk  in  1  system clock
reset_n  in  1  reset
frame_tick  in  1  one-cycle pulse per video frame
run  in  1  1 = game running, 0 = paused
game_over  in  1  collision flag; sticky halt
rand_val  in  12  LFSR state, used for period jitter
shape_update  out  1  one-cycle strobe to the shape generator
top_in / mid_in / bot_in  in  2 each  shape generator outputs
row_valid  out  1  FIFO head valid
row_ready  in  1  consumer accepts head
row_top / row_mid / row_bot  out  2 each  FIFO head lane shapes
level  out  4  difficulty level, saturates at 15
spawn_count  out  8  accepted rows, wraps at 255

Behaviour:
- Reset is reset_n: asynchronous, active-low. Clock is clk, rising edge.
- Reset values:
  - state IDLE, countdown 0, reroll 0
  - shape_update 0, row_valid 0, row_* 00
  - level 0, spawn_count 0, FIFO empty
- Lane rule: shape value 00 = lane clear; any nonzero value = lane blocked.
- period = max(INIT_PERIOD - level*STEP, MIN_PERIOD). Compute at 9-bit signed width so the subtraction cannot underflow.
- Reload value = period + rand_val[1:0], sampled at reload time.
- FSM states:
  - IDLE: when run=1, load countdown with the reload value and go to WAIT.
  - WAIT: act only on frame_tick with run=1.
    - countdown==1: go to UPDATE.
    - otherwise: decrement countdown.
    - With run=0, countdown is frozen and frame_ticks are ignored.
  - UPDATE: shape_update=1 for exactly this cycle, then go to SAMPLE.
  - SAMPLE: one settle cycle. Capture top_in/mid_in/bot_in into a holding register at the end of the cycle, then go to CHECK.
  - CHECK: if all three lanes are blocked:
    - reroll<MAX_REROLL: reroll++, go to UPDATE.
    - reroll==MAX_REROLL: force the held mid lane to 00, go to PUSH.
    - Otherwise go to PUSH.
  - PUSH: write the held row when the FIFO is not full, or when it is full and a pop occurs in the same cycle. On a write:
    - spawn_count++ and reroll=0
    - reload countdown, go to WAIT
    - If the write is blocked, stay in PUSH; frame_ticks are ignored and the countdown does not run.
  - HALT: entered from any state on the edge after game_over=1.
    - No further shape_update pulses.
    - row_valid forced to 0; FIFO contents and pointers frozen.
    - Exit only via reset.
- run=0 outside WAIT: the in-flight UPDATE/SAMPLE/CHECK/PUSH sequence completes normally, then the FSM pauses in WAIT.
- Level: when the incremented spawn_count is a nonzero multiple of SPAWNS_PER_LEVEL, level++ (saturate at 15). The new period applies to the reload in that same PUSH cycle.
- FIFO:
  - 4 entries x 6 bits, first-word-fall-through.
  - row_valid = !empty (and not HALT); row_* show the head entry.
  - Pop when row_valid & row_ready.
  - Simultaneous push and pop keeps occupancy unchanged.
  - Pop on empty has no effect.
  - row_* read 00 while empty.
- shape_update must never be asserted on two consecutive cycles. Minimum 3 cycles between strobes (UPDATE→SAMPLE→CHECK→UPDATE).
- reset_n asserted mid-operation returns every register to its reset value immediately, independent of clk.

Test Plan:
1. Reset, run=1, frame_tick every 10 cycles, rand_val[1:0]=0 → first shape_update is a single cycle, in the cycle after the 60th tick; none earlier.
2. Shape inputs 01/10/00, row_ready=1 → row_valid=1 with row_top=01, row_mid=10, row_bot=00; popped next edge; spawn_count=1.
3. Shape inputs held at 11/11/01 → exactly 4 shape_update pulses, each 3 cycles apart; then a row 11/00/01 is pushed and reroll is cleared.
4. row_ready=0 across 5 spawn intervals → FIFO holds 4 rows, FSM stalls in PUSH, spawn_count=4. Then row_ready=1 → fifth row written in the same cycle as the first pop; spawn_count=5.
5. 8 accepted rows → level=1 and the next interval is 56 ticks. After 80 rows: level=10, period 20. At level 11: period stays 20. At 120 rows: level saturates at 15.
6. game_over=1 mid-WAIT → HALT, row_valid=0, no strobes for 500 ticks. Then reset_n=0 between clock edges → all outputs zero immediately, state IDLE.
